// File: rtl/pbkdf2_pkg.sv
// Shared types and constants for the PBKDF2 iteration controller.
// Holds the FSM state type, the hash/INT widths and the o_key slot placement helper.
package pbkdf2_pkg;

    localparam int HLEN  = 256;
    localparam int INT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    // LSB position of block slot blk (1-based) inside a key of `blocks` slots; slot 1 is the MSB slot.
    function automatic int slot_lsb(input int blk, input int blocks);
        return (blocks - blk) * HLEN;
    endfunction

endpackage

// File: rtl/pbkdf2_xor_acc.sv
// U/T accumulator for one PBKDF2 block: U follows each MAC, T loads the first MAC then XOR-accumulates.
// t_next is the block result the controller stores when the last iteration of a block completes.
module pbkdf2_xor_acc
    import pbkdf2_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic            first,
    input  logic [HLEN-1:0] mac,
    output logic [HLEN-1:0] u,
    output logic [HLEN-1:0] t_next
);

    logic [HLEN-1:0] t;

    assign t_next = first ? mac : (t ^ mac);

    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            u <= '0;
            t <= '0;
        end else if (clr) begin
            t <= '0;
        end else if (load) begin
            u <= mac;
            t <= t_next;
        end
    end

endmodule

// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2 iteration controller: runtime iteration count, BLOCKS x 256-bit derived key,
// driving an external HMAC engine through a one-cycle req / done handshake.
module pbkdf2_iter_ctrl
    import pbkdf2_pkg::*;
#(
    parameter int PW_W   = 1088,
    parameter int SALT_W = 128,
    parameter int ITER_W = 16,
    parameter int BLOCKS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [PW_W-1:0]          i_pw,
    input  logic [SALT_W-1:0]        i_salt,
    input  logic [ITER_W-1:0]        i_iter,
    output logic                     o_busy,
    output logic                     o_hmac_req,
    output logic                     o_hmac_first,
    output logic [PW_W-1:0]          o_hmac_key,
    output logic [SALT_W+INT_W-1:0]  o_hmac_msg_salt,
    output logic [HLEN-1:0]          o_hmac_msg_u,
    input  logic                     i_hmac_done,
    input  logic [HLEN-1:0]          i_hmac_mac,
    output logic [HLEN*BLOCKS-1:0]   o_key,
    output logic                     o_ready,
    output logic                     o_err
);

    state_t              state;
    logic [PW_W-1:0]     pw_q;
    logic [SALT_W-1:0]   salt_q;
    logic [ITER_W-1:0]   iter_q;
    logic [ITER_W-1:0]   cnt;
    logic [INT_W-1:0]    blk;
    logic [HLEN-1:0]     u;
    logic [HLEN-1:0]     t_next;
    logic                acc_clr;
    logic                acc_load;

    // Abort outranks both start and done in the same cycle.
    assign acc_clr  = (state == IDLE) && i_start && !i_abort;
    assign acc_load = (state == WAIT) && i_hmac_done && !i_abort;

    pbkdf2_xor_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .load   (acc_load),
        .first  (cnt == ITER_W'(1)),
        .mac    (i_hmac_mac),
        .u      (u),
        .t_next (t_next)
    );

    assign o_hmac_key      = pw_q;
    assign o_hmac_msg_salt = {salt_q, blk};
    assign o_hmac_msg_u    = u;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_hmac_req   <= 1'b0;
            o_hmac_first <= 1'b0;
            o_ready      <= 1'b0;
            o_err        <= 1'b0;
            o_key        <= '0;
            pw_q         <= '0;
            salt_q       <= '0;
            iter_q       <= '0;
            cnt          <= '0;
            blk          <= '0;
        end else begin
            // NOTE: default-low here makes o_hmac_req a single-cycle pulse without extra clearing logic.
            o_hmac_req <= 1'b0;
            if (i_abort) begin
                state   <= IDLE;
                o_busy  <= 1'b0;
                o_ready <= 1'b0;
                o_err   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_start) begin
                            pw_q    <= i_pw;
                            salt_q  <= i_salt;
                            iter_q  <= i_iter;
                            o_ready <= 1'b0;
                            o_err   <= 1'b0;
                            if (i_iter == '0) begin
                                o_ready <= 1'b1;
                                o_err   <= 1'b1;
                                o_key   <= '0;
                            end else begin
                                blk          <= INT_W'(1);
                                cnt          <= ITER_W'(1);
                                state        <= REQ;
                                o_busy       <= 1'b1;
                                o_hmac_req   <= 1'b1;
                                o_hmac_first <= 1'b1;
                            end
                        end
                    end
                    REQ: state <= WAIT;
                    WAIT: begin
                        if (i_hmac_done) begin
                            if (cnt < iter_q) begin
                                cnt          <= cnt + 1'b1;
                                state        <= REQ;
                                o_hmac_req   <= 1'b1;
                                o_hmac_first <= 1'b0;
                            end else begin
                                for (int b = 0; b < BLOCKS; b++) begin
                                    if (blk == INT_W'(b + 1))
                                        o_key[slot_lsb(b + 1, BLOCKS) +: HLEN] <= t_next;
                                end
                                if (blk < INT_W'(BLOCKS)) begin
                                    blk          <= blk + 1'b1;
                                    cnt          <= ITER_W'(1);
                                    state        <= REQ;
                                    o_hmac_req   <= 1'b1;
                                    o_hmac_first <= 1'b1;
                                end else begin
                                    state   <= IDLE;
                                    o_busy  <= 1'b0;
                                    o_ready <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
